// File: rtl/warmboot_pkg.sv
// rtl/warmboot_pkg.sv - shared types and constants for the warmboot sequencer
package warmboot_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        FIRE  = 2'd2
    } wb_state_t;

    localparam logic [1:0] IMG_SPRINGBOARD = 2'd0;
    localparam logic [1:0] IMG_DFU         = 2'd1;
    localparam logic [1:0] IMG_USER        = 2'd2;
    localparam logic [1:0] IMG_INVALID     = 2'd3;

    localparam logic [7:0] DEFAULT_KEY = 8'hA5;

endpackage

// File: rtl/edge_detect.sv
// rtl/edge_detect.sv - single-bit rising-edge detector with registered history
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic prev;

    // History clears to 0, so a level already high out of reset reads as an edge
    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= 1'b0;
        end else begin
            prev <= d;
        end
    end

    assign rise = d & ~prev;

endmodule

// File: rtl/warmboot_ctrl.sv
// rtl/warmboot_ctrl.sv - reboot sequencer driving SB_WARMBOOT image select and BOOT
module warmboot_ctrl
    import warmboot_pkg::*;
#(
    parameter int unsigned DELAY_CYCLES = 48000,
    parameter logic [7:0]  KEY          = DEFAULT_KEY,
    parameter logic [1:0]  DFU_IMAGE    = IMG_DFU
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_req,
    input  logic [1:0] i_image,
    input  logic [7:0] i_key,
    input  logic       i_dfu_detach,
    input  logic       i_cancel,
    output logic       o_busy,
    output logic       o_rejected,
    output logic [1:0] o_mode,
    output logic       o_boot
);

    localparam int unsigned      CNT_W    = $clog2(DELAY_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DELAY_CYCLES - 1);

    if (DELAY_CYCLES < 2) begin : g_delay_check
        $error("warmboot_ctrl: DELAY_CYCLES must be at least 2");
    end

    wb_state_t        state;
    wb_state_t        next_state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] next_count;
    logic [1:0]       next_mode;
    logic             next_reject;
    logic             detach_rise;

    edge_detect u_detach_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (i_dfu_detach),
        .rise (detach_rise)
    );

    // Next-state decode: detach beats software request, cancel beats expiry
    always_comb begin
        next_state  = state;
        next_count  = count;
        next_mode   = o_mode;
        next_reject = 1'b0;
        unique case (state)
            IDLE: begin
                if (detach_rise) begin
                    next_state = SETUP;
                    next_mode  = DFU_IMAGE;
                    next_count = CNT_LOAD;
                end else if (i_req) begin
                    if (i_key == KEY && i_image != IMG_INVALID) begin
                        next_state = SETUP;
                        next_mode  = i_image;
                        next_count = CNT_LOAD;
                    end else begin
                        next_reject = 1'b1;
                    end
                end
            end
            SETUP: begin
                if (i_cancel) begin
                    next_state = IDLE;
                    next_mode  = IMG_SPRINGBOARD;
                    next_count = '0;
                end else if (count == '0) begin
                    next_state = FIRE;
                end else begin
                    next_count = count - CNT_W'(1);
                end
            end
            FIRE: begin
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State, counter and all outputs are registered; BOOT latches until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            o_mode     <= IMG_SPRINGBOARD;
            o_boot     <= 1'b0;
            o_busy     <= 1'b0;
            o_rejected <= 1'b0;
        end else begin
            state      <= next_state;
            count      <= next_count;
            o_mode     <= next_mode;
            o_boot     <= (next_state == FIRE);
            o_busy     <= (next_state != IDLE);
            o_rejected <= next_reject;
        end
    end

endmodule

// File: tb/tb_warmboot_ctrl.sv
// tb/tb_warmboot_ctrl.sv - scoreboard bench for warmboot_ctrl
module tb_warmboot_ctrl;

    localparam int D = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_req = 1'b0;
    logic [1:0] i_image = 2'd0;
    logic [7:0] i_key = 8'h00;
    logic       i_dfu_detach = 1'b0;
    logic       i_cancel = 1'b0;
    logic       o_busy;
    logic       o_rejected;
    logic [1:0] o_mode;
    logic       o_boot;

    always #5 clk = ~clk;

    warmboot_ctrl #(
        .DELAY_CYCLES (D),
        .KEY          (8'hA5),
        .DFU_IMAGE    (2'd1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_req        (i_req),
        .i_image      (i_image),
        .i_key        (i_key),
        .i_dfu_detach (i_dfu_detach),
        .i_cancel     (i_cancel),
        .o_busy       (o_busy),
        .o_rejected   (o_rejected),
        .o_mode       (o_mode),
        .o_boot       (o_boot)
    );

    // Edge counter: after rising edge N, cyc == N
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected output change: edge number and {busy, mode, boot, rejected}
    typedef struct {
        int         c;
        logic [4:0] v;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;
    bit    mon_en = 1'b0;

    task automatic push(input int c, input logic b, input logic [1:0] m,
                        input logic bt, input logic r, input string nm);
        exp_t e;
        e.c = c;
        e.v = {b, m, bt, r};
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Reset pulse from a busy state: outputs must all drop after that edge
    task automatic pulse_rst(input string nm);
        int r;
        r = cyc + 1;
        rst = 1'b1;
        push(r, 1'b0, 2'd0, 1'b0, 1'b0, nm);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic sw_req(input logic [7:0] key, input logic [1:0] img);
        i_req   = 1'b1;
        i_key   = key;
        i_image = img;
        @(negedge clk);
        i_req   = 1'b0;
    endtask

    // Monitor: every change of the output vector pops and checks one expectation
    logic [4:0] prev_v;
    logic [4:0] cur_v;
    bit         started = 1'b0;
    exp_t       ev;
    string      nm;
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            cur_v = {o_busy, o_mode, o_boot, o_rejected};
            if (!started || cur_v != prev_v) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: edge %0d busy/mode/boot/rej=%b, none expected", cyc, cur_v);
                end else begin
                    ev = exp_q.pop_front();
                    nm = name_q.pop_front();
                    if (ev.c != cyc || ev.v != cur_v) begin
                        errors++;
                        $display("FAIL %s: got edge %0d busy/mode/boot/rej=%b, want edge %0d %b",
                                 nm, cyc, cur_v, ev.c, ev.v);
                    end
                end
                started = 1'b1;
            end
            prev_v = cur_v;
        end
    end

    int e;
    int r;
    initial begin
        repeat (3) @(negedge clk);
        e = cyc + 1;
        push(e, 1'b0, 2'd0, 1'b0, 1'b0, "reset_state");
        rst = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        // Keyed request to user image, then BOOT holds for 100 cycles, reset in FIRE
        e = cyc + 1;
        push(e,     1'b1, 2'd2, 1'b0, 1'b0, "key_accept");
        push(e + D, 1'b1, 2'd2, 1'b1, 1'b0, "key_boot");
        sw_req(8'hA5, 2'd2);
        wait_until(e + D + 100);
        pulse_rst("rst_in_fire");
        repeat (2) @(negedge clk);

        // Wrong key, then invalid image: one-cycle reject pulses only
        e = cyc + 1;
        push(e,     1'b0, 2'd0, 1'b0, 1'b1, "bad_key");
        push(e + 1, 1'b0, 2'd0, 1'b0, 1'b0, "bad_key_end");
        sw_req(8'h5A, 2'd2);
        @(negedge clk);
        e = cyc + 1;
        push(e,     1'b0, 2'd0, 1'b0, 1'b1, "bad_image");
        push(e + 1, 1'b0, 2'd0, 1'b0, 1'b0, "bad_image_end");
        sw_req(8'hA5, 2'd3);
        repeat (3) @(negedge clk);

        // DFU detach rising edge
        e = cyc + 1;
        push(e,     1'b1, 2'd1, 1'b0, 1'b0, "dfu_accept");
        push(e + D, 1'b1, 2'd1, 1'b1, 1'b0, "dfu_boot");
        i_dfu_detach = 1'b1;
        wait_until(e + D + 5);
        i_dfu_detach = 1'b0;
        pulse_rst("rst_after_dfu");
        repeat (2) @(negedge clk);

        // Detach edge and keyed request together: DFU wins, no reject; cancel at count 3
        e = cyc + 1;
        push(e,     1'b1, 2'd1, 1'b0, 1'b0, "prio_accept");
        push(e + 5, 1'b0, 2'd0, 1'b0, 1'b0, "cancel_at_3");
        i_dfu_detach = 1'b1;
        sw_req(8'hA5, 2'd2);
        wait_until(e + 4);
        i_cancel = 1'b1;
        @(negedge clk);
        i_cancel = 1'b0;
        wait_until(e + 25);

        // Detach still high across reset counts as a fresh edge right after release
        r = cyc + 1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        push(r + 1, 1'b1, 2'd1, 1'b0, 1'b0, "detach_high_at_reset");
        push(r + 2, 1'b0, 2'd0, 1'b0, 1'b0, "cancel_first");
        @(negedge clk);
        i_cancel = 1'b1;
        @(negedge clk);
        i_cancel = 1'b0;
        i_dfu_detach = 1'b0;
        repeat (20) @(negedge clk);

        // Cancel on the count == 0 cycle still wins over firing
        e = cyc + 1;
        push(e,     1'b1, 2'd2, 1'b0, 1'b0, "c0_accept");
        push(e + 8, 1'b0, 2'd0, 1'b0, 1'b0, "cancel_at_0");
        sw_req(8'hA5, 2'd2);
        wait_until(e + 7);
        i_cancel = 1'b1;
        @(negedge clk);
        i_cancel = 1'b0;
        wait_until(e + 25);

        // Requests during SETUP are ignored; inputs in FIRE are ignored
        e = cyc + 1;
        push(e,     1'b1, 2'd2, 1'b0, 1'b0, "busy_accept");
        push(e + D, 1'b1, 2'd2, 1'b1, 1'b0, "busy_boot");
        sw_req(8'hA5, 2'd2);
        wait_until(e + 2);
        sw_req(8'hA5, 2'd0);
        sw_req(8'h00, 2'd1);
        wait_until(e + D + 2);
        i_cancel = 1'b1;
        i_dfu_detach = 1'b1;
        sw_req(8'hA5, 2'd0);
        i_cancel = 1'b0;
        i_dfu_detach = 1'b0;
        repeat (10) @(negedge clk);
        pulse_rst("rst_end");
        repeat (5) @(negedge clk);

        while (exp_q.size() > 0) begin
            ev = exp_q.pop_front();
            nm = name_q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: event never seen, want edge %0d busy/mode/boot/rej=%b", nm, ev.c, ev.v);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
